// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// cpu_defs : shared CPU constants and next-PC source encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IM_LO     = 32'h0000_3000;
   localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;

   typedef enum logic [2:0] {
      NPC_PC4    = 3'd0,
      NPC_BRANCH = 3'd1,
      NPC_JUMP   = 3'd2,
      NPC_JREG   = 3'd3
   } npc_sel_t;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ============================================================================
// npc_calc : combinational pc+4 / pc+8, branch-target and jump-target adders
// Rev 1.0
// ============================================================================
`default_nettype none

module npc_calc (
   input  logic [31:0] pc,
   input  logic [31:0] d_pc,
   input  logic [15:0] d_imm16,
   input  logic [25:0] d_index,
   output logic [31:0] pc4,
   output logic [31:0] pc8,
   output logic [31:0] br_target,
   output logic [31:0] j_target
);

   logic [31:0] w_dpc4;
   logic [31:0] w_br_off;

   // All sums wrap modulo 2^32; no carry-out is kept on purpose.
   assign pc4       = pc + 32'd4;
   assign pc8       = pc + 32'd8;
   assign w_dpc4    = d_pc + 32'd4;
   assign w_br_off  = {{14{d_imm16[15]}}, d_imm16, 2'b00};
   assign br_target = w_dpc4 + w_br_off;
   assign j_target  = {w_dpc4[31:28], d_index, 2'b00};

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : fetch-stage PC register, next-PC select and fetch fault check
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [2:0]  npc_sel,
   input  logic        br_taken,
   input  logic [31:0] d_pc,
   input  logic [15:0] d_imm16,
   input  logic [25:0] d_index,
   input  logic [31:0] jr_addr,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic [31:0] pc8,
   output logic        f_exc,
   output logic [4:0]  f_exc_code,
   output logic        f_bd
);

   logic [31:0] r_pc = PC_RESET;
   logic [31:0] w_pc4;
   logic [31:0] w_br_target;
   logic [31:0] w_j_target;
   logic [31:0] w_npc;
   logic        w_fault;

   npc_calc u_npc_calc (
      .pc        (r_pc),
      .d_pc      (d_pc),
      .d_imm16   (d_imm16),
      .d_index   (d_index),
      .pc4       (w_pc4),
      .pc8       (pc8),
      .br_target (w_br_target),
      .j_target  (w_j_target)
   );

   // CP0 redirects outrank the hazard stall; reset is applied in the register.
   always_comb begin
      w_npc = w_pc4;
      if (exc_req) begin
         w_npc = EXC_ENTRY;
      end else if (eret_req) begin
         w_npc = epc;
      end else if (stall) begin
         w_npc = r_pc;
      end else begin
         case (npc_sel_t'(npc_sel))
            NPC_BRANCH: w_npc = br_taken ? w_br_target : w_pc4;
            NPC_JUMP:   w_npc = w_j_target;
            NPC_JREG:   w_npc = jr_addr;
            default:    w_npc = w_pc4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= PC_RESET;
      end else begin
         r_pc <= w_npc;
      end
   end

   // The faulting address is still loaded; squashing happens downstream.
   assign w_fault    = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > IM_HI);
   assign pc         = r_pc;
   assign f_exc      = w_fault;
   assign f_exc_code = w_fault ? EXC_ADEL : 5'd0;
   assign f_bd       = (npc_sel != 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// tb_pc_fetch_unit : directed and randomized checks against a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, br_taken, exc_req, eret_req;
   logic [2:0]  npc_sel;
   logic [31:0] d_pc, jr_addr, epc;
   logic [15:0] d_imm16;
   logic [25:0] d_index;
   logic [31:0] pc, pc8;
   logic        f_exc, f_bd;
   logic [4:0]  f_exc_code;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] m_pc     = 32'h3000;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .npc_sel    (npc_sel),
      .br_taken   (br_taken),
      .d_pc       (d_pc),
      .d_imm16    (d_imm16),
      .d_index    (d_index),
      .jr_addr    (jr_addr),
      .exc_req    (exc_req),
      .eret_req   (eret_req),
      .epc        (epc),
      .pc         (pc),
      .pc8        (pc8),
      .f_exc      (f_exc),
      .f_exc_code (f_exc_code),
      .f_bd       (f_bd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic model_fault(input logic [31:0] a);
      return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
   endfunction

   function automatic logic [31:0] model_next();
      int signed   off;
      logic [31:0] seq;
      seq = m_pc + 32'd4;
      off = 4 * int'($signed(d_imm16));
      if (reset)    return 32'h3000;
      if (exc_req)  return 32'h4180;
      if (eret_req) return epc;
      if (stall)    return m_pc;
      if (npc_sel == 3'd1) return br_taken ? (d_pc + 32'd4 + 32'(off)) : seq;
      if (npc_sel == 3'd2) return {((d_pc + 32'd4) >> 28), d_index, 2'b00};
      if (npc_sel == 3'd3) return jr_addr;
      return seq;
   endfunction

   task automatic drive(input logic rst, input logic stl, input logic [2:0] sel,
                        input logic br, input logic [31:0] dpc, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jr,
                        input logic exc, input logic eret, input logic [31:0] ep);
      logic [31:0] nxt;
      reset = rst; stall = stl; npc_sel = sel; br_taken = br; d_pc = dpc;
      d_imm16 = imm; d_index = idx; jr_addr = jr; exc_req = exc; eret_req = eret; epc = ep;
      @(negedge clk);
      check("pc", pc, m_pc);
      check("pc8", pc8, m_pc + 32'd8);
      check("f_exc", 32'(f_exc), 32'(model_fault(m_pc)));
      check("f_exc_code", 32'(f_exc_code), model_fault(m_pc) ? 32'd4 : 32'd0);
      check("f_bd", 32'(f_bd), 32'(sel != 3'd0));
      nxt = model_next();
      @(posedge clk);
      #1;
      m_pc = nxt;
   endtask

   task automatic seq0();
      drive(0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0);
   endtask

   task automatic jr_to(input logic [31:0] a);
      drive(0, 0, 3, 0, 32'h0, 16'h0, 26'h0, a, 0, 0, 32'h0);
   endtask

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return 32'($urandom_range(32'h3000, 32'h6FFC)) & 32'hFFFF_FFFC;
   endfunction

   initial begin
      #1;
      // reset held two cycles, then sequential fetch
      drive(1, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0);
      drive(1, 1, 2, 1, 32'h0, 16'h0, 26'h0, 32'h0, 1, 1, 32'h0);
      check("reset_pc", pc, 32'h3000);
      check("reset_pc8", pc8, 32'h3008);
      seq0(); check("seq1", pc, 32'h3004);
      seq0(); check("seq2", pc, 32'h3008);
      seq0(); check("seq3", pc, 32'h300C);

      // branch taken backwards, then not-taken from 0x3014
      drive(0, 0, 1, 1, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 0, 0, 32'h0);
      check("br_taken", pc, 32'h3004);
      jr_to(32'h3014);
      drive(0, 0, 1, 0, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 0, 0, 32'h0);
      check("br_not_taken", pc, 32'h3018);

      // jump, then misaligned jr
      drive(0, 0, 2, 0, 32'h3020, 16'h0, 26'h0000D00, 32'h0, 0, 0, 32'h0);
      check("jump", pc, 32'h3400);
      jr_to(32'h3002);
      check("jr_misaligned", pc, 32'h3002);
      check("jr_f_exc", 32'(f_exc), 32'd1);
      check("jr_f_code", 32'(f_exc_code), 32'd4);

      // stall against redirects
      jr_to(32'h3200);
      for (int i = 0; i < 3; i++)
         drive(0, 1, 2, 0, 32'h3020, 16'h0, 26'h0000D00, 32'h0, 0, 0, 32'h0);
      check("stall_hold", pc, 32'h3200);
      drive(0, 1, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h0);
      check("stall_exc", pc, 32'h4180);
      drive(0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 1, 1, 32'h3100);
      check("exc_over_eret", pc, 32'h4180);

      // eret and range limits
      drive(0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 1, 32'h3100);
      check("eret", pc, 32'h3100);
      jr_to(32'h6FF8);
      seq0(); check("hi_pc", pc, 32'h6FFC); check("hi_ok", 32'(f_exc), 32'd0);
      seq0(); check("past_hi", pc, 32'h7000); check("past_hi_exc", 32'(f_exc), 32'd1);
      jr_to(32'hFFFF_FFFC);
      check("wrap_pc8", pc8, 32'h0000_0004);
      seq0(); check("wrap_pc", pc, 32'h0);

      // reset mid-stall, mid-exception
      drive(1, 1, 3, 0, 32'h0, 16'h0, 26'h0, 32'h5000, 1, 1, 32'h3100);
      check("reset_override", pc, 32'h3000);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
               3'($urandom_range(0, 7)), 1'($urandom), rnd_addr(), 16'($urandom),
               26'($urandom), rnd_addr(), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 19) == 0), rnd_addr());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have stall, input, 1, hazard freeze from the decode-stage hazard unit.
REQ-004 SHALL have npc_sel, input, 3, next-PC source: 0 PC+4, 1 branch, 2 j/jal, 3 jr/jalr.
REQ-005 SHALL have br_taken, input, 1, branch condition result for the instruction in D.
REQ-006 SHALL have d_pc, input, 32, PC of the instruction currently in D.
REQ-007 SHALL have d_imm16, input, 16, branch offset field of the D instruction.
REQ-008 SHALL have d_index, input, 26, jump index field of the D instruction.
REQ-009 SHALL have jr_addr, input, 32, forwarded rs value for jr/jalr.
REQ-010 SHALL have exc_req, input, 1, exception/interrupt redirect from CP0.
REQ-011 SHALL have eret_req, input, 1, eret redirect from CP0.
REQ-012 SHALL have epc, input, 32, return address from CP0.
REQ-013 SHALL have pc, output, 32, address of the instruction being fetched this cycle (registered).
REQ-014 SHALL have pc8, output, 32, pc+8 link value.
REQ-015 SHALL have f_exc, output, 1, fetch address fault flag.
REQ-016 SHALL have f_exc_code, output, 5, ExcCode for the fault (4 = AdEL) or 0.
REQ-017 SHALL have f_bd, output, 1, set when the fetched instruction is in a delay slot (npc_sel != 0 this cycle).

Function
REQ-018 SHALL load pc on every rising clk edge from the next-PC value selected by REQ-019; no other state changes pc.
REQ-019 SHALL use the following priority, highest first: reset -> 0x00003000; exc_req -> 0x00004180; eret_req -> epc; stall -> hold pc; npc_sel 1 with br_taken -> branch target; npc_sel 1 without br_taken -> pc+4; npc_sel 2 -> jump target; npc_sel 3 -> jr_addr; npc_sel 0 or 4..7 -> pc+4.
REQ-020 SHALL compute the branch target as d_pc + 4 + (sign-extended d_imm16 << 2), modulo 2^32.
REQ-021 SHALL compute the jump target as {(d_pc+4)[31:28], d_index, 2'b00}.
REQ-022 SHALL compute pc+4 and pc8 modulo 2^32, with wrap at 0xFFFFFFFC and no fault raised by the wrap itself.
REQ-023 SHALL make exc_req and eret_req override stall in the same cycle.
REQ-024 SHALL make exc_req win when exc_req and eret_req are asserted together.
REQ-025 SHALL assert f_exc combinationally, with f_exc_code = 4, when pc[1:0] != 0 or pc lies outside 0x00003000..0x00006FFC inclusive; otherwise f_exc = 0 and f_exc_code = 0.
REQ-026 SHALL still advance pc normally on a fault; pipeline squash of the faulting instruction belongs to the fetch/decode register and CP0.
REQ-027 SHALL drive f_bd = 1 whenever npc_sel != 0, whatever the br_taken value.
REQ-028 SHALL load a misaligned jr_addr or epc without modification, so the fault appears on f_exc in the following cycle.

Reset
REQ-029 SHALL set pc = 0x00003000 on any clock edge with reset = 1, overriding every other input, including mid-stall and mid-exception.
REQ-030 SHALL take its simulation initial value of pc as 0x00003000.
REQ-031 SHALL produce, in the cycle after reset, pc8 = 0x00003008, f_exc = 0, f_exc_code = 0, and f_bd = npc_sel != 0.

Structure
REQ-032 SHALL take the following constants from the shared cpu_defs package: PC_RESET = 0x00003000, EXC_ENTRY = 0x00004180, IM_LO = 0x00003000, IM_HI = 0x00006FFC, EXC_ADEL = 4, and the NPC_SEL encodings.
REQ-033 SHALL place the branch-target, jump-target and pc+4 arithmetic in one combinational sub-module, npc_calc.
REQ-034 SHALL keep the pc register and the fault detection in pc_fetch_unit.

Verification
REQ-035 SHALL cover reset: reset held 2 cycles, then npc_sel = 0 for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; f_exc = 0 throughout.
REQ-036 SHALL cover branches: d_pc = 0x3010, d_imm16 = 0xFFFC, npc_sel = 1, br_taken = 1 -> next pc = 0x3004 and f_bd = 1; repeating with br_taken = 0 from pc 0x3014 -> next pc = 0x3018.
REQ-037 SHALL cover jumps: d_pc = 0x3020, d_index = 0x0000D00, npc_sel = 2 -> next pc = 0x00003400; npc_sel = 3 with jr_addr = 0x3002 -> next pc = 0x3002, then f_exc = 1 and f_exc_code = 4.
REQ-038 SHALL cover stall against redirects: stall = 1 for 3 cycles with npc_sel = 2 -> pc held; stall = 1 with exc_req = 1 -> next pc = 0x4180; exc_req and eret_req both set with epc = 0x3100 -> 0x4180.
REQ-039 SHALL cover eret and range limits: eret_req = 1, epc = 0x3100 -> next pc = 0x3100; pc reaching 0x6FFC -> f_exc = 0, next pc 0x7000 -> f_exc = 1.
